// File: rtl/spmdv_pkg.sv
// Shared constants and types for the SpMDV output packer.
package spmdv_pkg;

    localparam int RESULT_W  = 22;
    localparam int VEC_LEN   = 256;
    localparam int NUM_VEC   = 16;
    localparam int VEC_IDX_W = $clog2(NUM_VEC);
    localparam int RES_CNT_W = 8;
    localparam int LANES     = 4;
    localparam int WORD_W    = 32;
    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;

    // One FIFO entry: packed bytes plus the framing that travels with them.
    typedef struct packed {
        logic [WORD_W-1:0]    data;
        logic                 last;
        logic [VEC_IDX_W-1:0] vec_idx;
    } fifo_word_t;

endpackage

// File: rtl/spmdv_fifo.sv
// First-word-fall-through FIFO for packed output words.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module spmdv_fifo
    import spmdv_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_word_t  push_word,
    input  logic        pop,
    output fifo_word_t  head_word,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    fifo_word_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              wr_en;
    logic              rd_en;

    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign wr_en     = push && (!full || pop);
    assign rd_en     = pop && !empty;
    assign head_word = mem[rd_ptr_reg];

    // Storage write; contents are datapath only and are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= push_word;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spmdv_out_packer.sv
// Requantises 22-bit SpMDV results to int8, packs four per 32-bit word,
// tags words with vector framing and buffers them in an output FIFO.
module spmdv_out_packer
    import spmdv_pkg::*;
#(
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int VEC_LEN    = spmdv_pkg::VEC_LEN,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RESULT_W-1:0]  i_result,
    input  logic                 i_valid,
    input  logic                 relu_en,
    input  logic                 clr_ovf,
    input  logic                 i_ready,
    output logic [WORD_W-1:0]    o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic [VEC_IDX_W-1:0] o_vec_idx,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_ovf
);

    // Half-LSB rounding constant; zero when no shift is applied.
    localparam logic signed [RESULT_W:0] ROUND_ADD = (RESULT_W + 1)'((2 ** SHIFT) >> 1);
    localparam logic signed [RESULT_W:0] SAT_HI    = (RESULT_W + 1)'(INT8_MAX);
    localparam logic signed [RESULT_W:0] SAT_LO    = (RESULT_W + 1)'(INT8_MIN);
    localparam logic [RES_CNT_W-1:0]     LAST_RES  = RES_CNT_W'(VEC_LEN - 1);

    logic signed [RESULT_W:0] ext_val;
    logic signed [RESULT_W:0] rounded_val;
    logic signed [RESULT_W:0] shifted_val;
    logic [7:0]               q_byte;

    logic                     s1_valid_reg;
    logic [7:0]               s1_byte_reg;
    logic [1:0]               lane_reg;
    logic [RES_CNT_W-1:0]     res_cnt_reg;
    logic [VEC_IDX_W-1:0]     vec_cnt_reg;
    logic                     pk_last_reg;
    logic                     push_reg;
    logic [WORD_W-1:0]        pk_data;
    logic                     is_last_res;

    fifo_word_t               push_word;
    fifo_word_t               head_word;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    logic                     ovf_set;

    // Requantise: one extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        ext_val     = {i_result[RESULT_W-1], i_result};
        rounded_val = ext_val + ROUND_ADD;
        shifted_val = rounded_val >>> SHIFT;
        if (relu_en && shifted_val[RESULT_W]) begin
            q_byte = 8'h00;
        end else if (shifted_val > SAT_HI) begin
            q_byte = 8'h7F;
        end else if (shifted_val < SAT_LO) begin
            q_byte = 8'h80;
        end else begin
            q_byte = shifted_val[7:0];
        end
    end

    // Stage 1: register the quantised byte and its valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_byte_reg  <= '0;
        end else begin
            s1_valid_reg <= i_valid;
            if (i_valid) s1_byte_reg <= q_byte;
        end
    end

    assign is_last_res = (res_cnt_reg == LAST_RES);

    // One byte register per lane; a stage-1 byte lands in the lane currently selected.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] byte_reg;
            // Capture the byte when this lane is the write target.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    byte_reg <= '0;
                end else if (s1_valid_reg && lane_reg == 2'(gi)) begin
                    byte_reg <= s1_byte_reg;
                end
            end
            assign pk_data[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    // Lane, result and vector counters; a completed word is pushed on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_reg    <= '0;
            res_cnt_reg <= '0;
            vec_cnt_reg <= '0;
            pk_last_reg <= 1'b0;
            push_reg    <= 1'b0;
        end else begin
            push_reg <= s1_valid_reg && (lane_reg == 2'd3);
            if (s1_valid_reg) begin
                lane_reg    <= lane_reg + 2'd1;
                res_cnt_reg <= is_last_res ? '0 : res_cnt_reg + 1'b1;
                pk_last_reg <= (lane_reg == 2'd0) ? is_last_res : (pk_last_reg | is_last_res);
            end
            // The vector index advances on the last word even if that word is dropped.
            if (push_reg && pk_last_reg) vec_cnt_reg <= vec_cnt_reg + 1'b1;
        end
    end

    assign push_word = {pk_data, pk_last_reg, vec_cnt_reg};
    assign pop       = !fifo_empty && i_ready;
    assign ovf_set   = push_reg && fifo_full && !pop;

    spmdv_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_reg),
        .push_word (push_word),
        .pop       (pop),
        .head_word (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_count)
    );

    // Sticky overflow flag; a new overflow takes priority over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ovf <= 1'b0;
        end else if (ovf_set) begin
            o_ovf <= 1'b1;
        end else if (clr_ovf) begin
            o_ovf <= 1'b0;
        end
    end

    assign o_valid   = !fifo_empty;
    assign o_data    = fifo_empty ? '0 : head_word.data;
    assign o_last    = fifo_empty ? 1'b0 : head_word.last;
    assign o_vec_idx = fifo_empty ? '0 : head_word.vec_idx;

endmodule

// File: tb/tb_spmdv_out_packer.sv
// Scoreboard bench for spmdv_out_packer: stimulus feeds a behavioural model that
// queues expected words; a monitor compares every presented output word.
module tb_spmdv_out_packer;
    import spmdv_pkg::*;

    localparam int SHIFT = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [RESULT_W-1:0]  i_result = '0;
    logic                 i_valid = 1'b0;
    logic                 relu_en = 1'b0;
    logic                 clr_ovf = 1'b0;
    logic                 i_ready = 1'b0;
    logic [WORD_W-1:0]    o_data;
    logic                 o_valid;
    logic                 o_last;
    logic [VEC_IDX_W-1:0] o_vec_idx;
    logic [CW-1:0]        o_count;
    logic                 o_ovf;

    spmdv_out_packer #(
        .SHIFT(SHIFT),
        .FIFO_DEPTH(DEPTH),
        .VEC_LEN(256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_result  (i_result),
        .i_valid   (i_valid),
        .relu_en   (relu_en),
        .clr_ovf   (clr_ovf),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .o_vec_idx (o_vec_idx),
        .o_count   (o_count),
        .o_ovf     (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  vec;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    bit         rnd_ready = 1'b0;

    // Reference model state: result position in vector, vector number, pending bytes.
    int         m_idx = 0;
    int         m_vec = 0;
    bit         m_last = 1'b0;
    logic [7:0] m_bytes[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ref_q(input logic [21:0] r);
        int v;
        v = {{10{r[21]}}, r};
        if (SHIFT > 0) v = v + (1 << (SHIFT - 1));
        v = v >>> SHIFT;
        if (relu_en && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic model_reset();
        m_idx = 0;
        m_vec = 0;
        m_last = 1'b0;
        m_bytes.delete();
        sb.delete();
    endtask

    task automatic model_add(input logic [21:0] r, input bit keep);
        exp_t e;
        m_bytes.push_back(ref_q(r));
        if (m_idx == 255) m_last = 1'b1;
        m_idx = (m_idx + 1) % 256;
        if (m_bytes.size() == 4) begin
            e.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            e.last = m_last;
            e.vec  = 4'(m_vec);
            if (keep) sb.push_back(e);
            if (m_last) m_vec = (m_vec + 1) % 16;
            m_last = 1'b0;
            m_bytes.delete();
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int r, input bit keep);
        i_valid  = 1'b1;
        i_result = 22'(r);
        model_add(22'(r), keep);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rnd_ready = 1'b0;
        i_ready   = 1'b1;
        idle(4);
        n = 0;
        while ((sb.size() != 0 || o_valid) && n < 300) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(n >= 300), 64'(0));
    endtask

    // Monitor: every presented word must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rst && o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%08h required=none", o_data);
            end else begin
                check("o_data", 64'(o_data), 64'(sb[0].data));
                check("o_last", 64'(o_last), 64'(sb[0].last));
                check("o_vec_idx", 64'(o_vec_idx), 64'(sb[0].vec));
                if (i_ready) begin
                    $display("word data=%08h last=%0d vec=%0d", o_data, o_last, o_vec_idx);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", 64'(o_valid), 64'(0));
        check("rst_o_last", 64'(o_last), 64'(0));
        check("rst_o_data", 64'(o_data), 64'(0));
        check("rst_o_vec_idx", 64'(o_vec_idx), 64'(0));
        check("rst_o_count", 64'(o_count), 64'(0));
        check("rst_o_ovf", 64'(o_ovf), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_ready = 1'b1;
        idle(2);

        // Rounding, negative values, ReLU
        send(71, 1'b1);
        send(-40, 1'b1);
        send(8, 1'b1);
        send(24, 1'b1);
        idle(3);
        relu_en = 1'b1;
        idle(1);
        send(-40, 1'b1);
        send(71, 1'b1);
        send(-1, 1'b1);
        send('h1FFFFF, 1'b1);
        idle(3);
        relu_en = 1'b0;
        idle(1);

        // Saturation at both extremes
        send('h1FFFFF, 1'b1);
        send('h200000, 1'b1);
        send(-2048, 1'b1);
        send(40, 1'b1);
        drain();

        // Latency: word visible two edges after the edge sampling the 4th result
        send(8, 1'b1);
        send(24, 1'b1);
        send(40, 1'b1);
        send(56, 1'b1);
        check("lat_valid_early", 64'(o_valid), 64'(0));
        tick();
        check("lat_valid_early2", 64'(o_valid), 64'(0));
        tick();
        check("lat_valid", 64'(o_valid), 64'(1));
        check("lat_data", 64'(o_data), 64'h04030201);
        drain();

        // Partial word discarded by reset
        i_valid = 1'b1;
        i_result = 22'(100);
        tick();
        i_result = 22'(200);
        tick();
        i_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        tick();
        check("mid_rst_count", 64'(o_count), 64'(0));
        check("mid_rst_valid", 64'(o_valid), 64'(0));
        rst = 1'b1;
        idle(1);
        send(16, 1'b1);
        send(32, 1'b1);
        send(48, 1'b1);
        send(64, 1'b1);
        drain();

        // Random traffic over two full vectors with random backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 252 + 256; i++) begin
            if (i == 252) begin
                idle(2);
                relu_en = 1'b1;
                idle(1);
            end
            if ($urandom_range(0, 3) == 0) send(int'($urandom), 1'b1);
            else send(int'($urandom_range(0, 8191)) - 4096, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();
        relu_en = 1'b0;
        check("rand_ovf", 64'(o_ovf), 64'(0));

        // Overflow: 17 words with no pops, 17th dropped
        i_ready = 1'b0;
        for (int i = 0; i < 68; i++) send($urandom_range(0, 2047), i < 64);
        idle(4);
        check("ovf_count", 64'(o_count), 64'(16));
        check("ovf_flag", 64'(o_ovf), 64'(1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", 64'(o_ovf), 64'(0));

        // Clear coincident with a new overflow: set wins
        for (int i = 0; i < 4; i++) send($urandom_range(0, 2047), 1'b0);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("set_wins_ovf", 64'(o_ovf), 64'(1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared2", 64'(o_ovf), 64'(0));

        // Full FIFO: push and pop on the same edge
        for (int i = 0; i < 4; i++) send($urandom_range(0, 2047), 1'b1);
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("full_pp_count", 64'(o_count), 64'(16));
        check("full_pp_ovf", 64'(o_ovf), 64'(0));
        idle(2);
        check("full_pp_count2", 64'(o_count), 64'(16));
        drain();

        check("final_count", 64'(o_count), 64'(0));
        check("final_ovf", 64'(o_ovf), 64'(0));
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
